cache_fill_arbiter: RTL and testbench
=====================================

Name: cache_fill_arbiter

Overview:
- Shares the single multi-cycle unified main memory between the I-cache miss path (IF stage) and the D-cache miss/write-through path (MEM stage) of the 5-stage pipeline.
- On a miss it sequences a full 8-word block fill: 8 pipelined word reads, with returned words steered into the requesting cache's data array.
- On a D-side store it issues one write-through cycle.
- Requests are serialized; D side has fixed priority over I side.

Parameters:
- WORDS_PER_BLOCK, 8: 16-bit words per cache block (16-byte block).
- MEM_LAT, 4: cycles from read issue to its mem_valid return.
- ADDR_W, 16: byte-address width.
- DATA_W, 16: word width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- icache_miss  in  1  I-cache miss request, level, held until i_done
- icache_addr  in  16  I-cache miss byte address
- dcache_miss  in  1  D-cache read-miss request, level, held until d_done
- dcache_wr  in  1  D-cache write-through request, level, held until d_done
- dcache_addr  in  16  D-cache miss/store byte address
- dcache_wdata  in  16  store data
- mem_en  out  1  memory access strobe, one access per cycle
- mem_wr  out  1  1 = write, 0 = read (valid with mem_en)
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_valid  in  1  mem_rdata valid; returns the read issued MEM_LAT cycles earlier
- fill_data  out  16  word to write into the cache data array (= mem_rdata)
- fill_word  out  3  word offset within the block for fill_data
- ifill_we  out  1  I-cache data array write enable
- dfill_we  out  1  D-cache data array write enable
- i_done  out  1  one-cycle pulse: I fill complete
- d_done  out  1  one-cycle pulse: D fill or write complete
- busy  out  1  FSM not in IDLE

Behaviour:
- States: IDLE, IFILL, DFILL, WRITE, FINISH. Register the grant owner (I/D) on leaving IDLE.
- Reset (async, rst_n = 0):
  - state = IDLE; issue_cnt = ret_cnt = 0.
  - All outputs 0: mem_en, mem_wr, ifill_we, dfill_we, i_done, d_done, busy, mem_addr, mem_wdata, fill_word.
- IDLE arbitration (priority order):
  - dcache_wr → WRITE.
  - else dcache_miss → DFILL.
  - else icache_miss → IFILL.
  - else stay in IDLE.
- Simultaneous dcache_wr and dcache_miss: treat as a protocol error. Write wins.
- Fill base address = {addr[15:4], 4'b0000}, latched on IDLE exit.
- IFILL / DFILL:
  - Issue: mem_en = 1, mem_wr = 0, mem_addr = base + 2*issue_cnt. issue_cnt increments each cycle for 8 cycles (0..7), then mem_en = 0.
  - Return: on each mem_valid in a fill state:
    - fill_data = mem_rdata; fill_word = ret_cnt.
    - ifill_we (IFILL) or dfill_we (DFILL) = 1, combinational with mem_valid.
    - ret_cnt increments.
  - When mem_valid arrives with ret_cnt = 7 → FINISH.
- WRITE: exactly one cycle.
  - mem_en = 1, mem_wr = 1, mem_addr = dcache_addr (unaligned, byte address), mem_wdata = dcache_wdata.
  - Next state FINISH.
- FINISH: one cycle.
  - i_done or d_done = 1 per the grant owner. No memory access.
  - Next state IDLE. The requester deasserts its request in this cycle, so IDLE never re-grants a stale request.
- No preemption: a D request arriving mid-I-fill waits until IDLE.
- Latency: request seen in IDLE at cycle 0.
  - Fill: issues in cycles 1–8, returns in cycles 5–12, done in cycle 13.
  - Write: mem write in cycle 1, done in cycle 2.
- mem_valid outside IFILL/DFILL is ignored: no fill_we.
- Counters are 3 bits. issue_cnt saturates at 8 issued via a separate issued-all flag; no wrap re-issue.
- busy = (state != IDLE).
- Reset mid-fill: abort immediately. In-flight returns after reset are ignored; no done pulse is produced.

Decomposition:
- Package cpu_mem_pkg:
  - State enum.
  - BLOCK_OFFSET_BITS = 4, WORD_IDX_W = 3.
  - Grant-owner encoding (GNT_I, GNT_D).
- Sub-module fill_counter: 3-bit counter with enable, synchronous clear, async reset, and terminal-count output. Instantiate twice: issue and return.

Test Plan:
- I miss only, icache_addr = 0x1236, memory word at A = A ^ 0xBEEF:
  - mem_addr 0x1230, 0x1232, …, 0x123E in cycles 1–8.
  - ifill_we with fill_word 0..7 in cycles 5–12, fill_data 0x1230^0xBEEF, ….
  - i_done in cycle 13; dfill_we never asserts.
- Simultaneous icache_miss (0x0040) and dcache_miss (0x8008):
  - D fill of block 0x8000 first, d_done in cycle 13.
  - Then I fill of block 0x0040 starts in cycle 15, i_done in cycle 27.
- dcache_wr, addr 0x2004, data 0xA5A5:
  - Cycle 1: mem_en = 1, mem_wr = 1, mem_addr 0x2004, mem_wdata 0xA5A5.
  - Cycle 2: d_done; no fill_we.
- dcache_wr raised in cycle 3 of an I fill: write waits; mem_en/mem_wr write cycle occurs only after i_done + IDLE.
- rst_n low in cycle 6 of a D fill: all outputs 0 immediately; mem_valid pulses in cycles 7–12 produce no dfill_we and no d_done.
- Spurious mem_valid in IDLE: no ifill_we/dfill_we; state remains IDLE.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the cache fill arbiter and its helpers.
package cpu_mem_pkg;

  localparam int unsigned WORDS_PER_BLOCK   = 8;
  localparam int unsigned MEM_LAT           = 4;
  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned DATA_W            = 16;
  localparam int unsigned BLOCK_OFFSET_BITS = 4;
  localparam int unsigned WORD_IDX_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IFILL  = 3'd1,
    ST_DFILL  = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  // Byte address of the first word of the block containing addr.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1);
  endfunction

  // Byte address of word idx within the block starting at base.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0]     base,
                                                  input logic [WORD_IDX_W-1:0] idx);
    return base | ADDR_W'({idx, 1'b0});
  endfunction

endpackage

// File: rtl/fill_counter.sv
// Word counter for one block transfer.
// Ports: clk, rst_n (async, active low); en advances the count; clr zeroes it
// (clr wins over en); count is the current word index; terminal_c is high while
// count sits on the last word of the block.
module fill_counter
  import cpu_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  output logic [WORD_IDX_W-1:0] count,
  output logic                  terminal_c
);

  // Count register; wraps naturally after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WORD_IDX_W'(1);
    end
  end

  assign terminal_c = (count == WORD_IDX_W'(WORDS_PER_BLOCK - 1));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Serializes I-cache and D-cache traffic onto the single main-memory port.
// A miss becomes an 8-word pipelined block fill whose returned words are
// steered into the requesting cache; a D-side store becomes one write cycle.
// The D side has fixed priority and nothing is preempted.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   icache_miss, icache_addr           I-side fill request (level) and address
//   dcache_miss, dcache_wr             D-side fill / write-through requests
//   dcache_addr, dcache_wdata          D-side address and store data
//   mem_en, mem_wr, mem_addr,
//   mem_wdata                          memory command port (registered)
//   mem_rdata, mem_valid               memory read return
//   fill_data, fill_word               word and offset for the cache array
//   ifill_we, dfill_we                 array write enables (follow mem_valid)
//   i_done, d_done                     one-cycle completion pulses
//   busy                               arbiter not idle
module cache_fill_arbiter
  import cpu_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  icache_miss,
  input  logic [ADDR_W-1:0]     icache_addr,
  input  logic                  dcache_miss,
  input  logic                  dcache_wr,
  input  logic [ADDR_W-1:0]     dcache_addr,
  input  logic [DATA_W-1:0]     dcache_wdata,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_valid,
  output logic [DATA_W-1:0]     fill_data,
  output logic [WORD_IDX_W-1:0] fill_word,
  output logic                  ifill_we,
  output logic                  dfill_we,
  output logic                  i_done,
  output logic                  d_done,
  output logic                  busy
);

  state_e              state_q, state_d;
  gnt_e                gnt_q, gnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                issued_all_q, issued_all_d;

  logic                mem_en_d, mem_wr_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                i_done_d, d_done_d, busy_d;

  logic                in_fill_c, fill_we_c, issue_en_c, cnt_clr_c;
  logic [WORD_IDX_W-1:0] issue_cnt, ret_cnt;
  logic                issue_tc_c, ret_tc_c;

  assign in_fill_c  = (state_q == ST_IFILL) || (state_q == ST_DFILL);
  // Returns only count while a fill owns the port; stray beats are dropped.
  assign fill_we_c  = in_fill_c & mem_valid;
  // A read command is on the port this cycle.
  assign issue_en_c = in_fill_c & mem_en & ~mem_wr;
  assign cnt_clr_c  = (state_q == ST_IDLE);

  fill_counter u_issue_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (issue_en_c),
    .clr        (cnt_clr_c),
    .count      (issue_cnt),
    .terminal_c (issue_tc_c)
  );

  fill_counter u_ret_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (fill_we_c),
    .clr        (cnt_clr_c),
    .count      (ret_cnt),
    .terminal_c (ret_tc_c)
  );

  // Cache array write side follows the memory return directly.
  assign fill_data = mem_rdata;
  assign fill_word = ret_cnt;
  assign ifill_we  = fill_we_c & (state_q == ST_IFILL);
  assign dfill_we  = fill_we_c & (state_q == ST_DFILL);

  // Next-state and next-output logic; memory command is computed one cycle ahead.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    base_d       = base_q;
    issued_all_d = issued_all_q;
    mem_en_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        issued_all_d = 1'b0;
        // A write together with a read miss is a requester bug; the write wins.
        if (dcache_wr) begin
          state_d     = ST_WRITE;
          gnt_d       = GNT_D;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = dcache_addr;
          mem_wdata_d = dcache_wdata;
        end else if (dcache_miss) begin
          state_d    = ST_DFILL;
          gnt_d      = GNT_D;
          base_d     = block_base(dcache_addr);
          mem_en_d   = 1'b1;
          mem_addr_d = block_base(dcache_addr);
        end else if (icache_miss) begin
          state_d    = ST_IFILL;
          gnt_d      = GNT_I;
          base_d     = block_base(icache_addr);
          mem_en_d   = 1'b1;
          mem_addr_d = block_base(icache_addr);
        end
      end

      ST_IFILL, ST_DFILL: begin
        if (issue_en_c && issue_tc_c) begin
          issued_all_d = 1'b1;
        end
        // Keep issuing back-to-back until the last word has gone out.
        if (issue_en_c && !issue_tc_c && !issued_all_q) begin
          mem_en_d   = 1'b1;
          mem_addr_d = word_addr(base_q, WORD_IDX_W'(issue_cnt + 1));
        end
        if (fill_we_c && ret_tc_c) begin
          state_d  = ST_FINISH;
          i_done_d = (gnt_q == GNT_I);
          d_done_d = (gnt_q == GNT_D);
        end
      end

      ST_WRITE: begin
        state_d  = ST_FINISH;
        i_done_d = (gnt_q == GNT_I);
        d_done_d = (gnt_q == GNT_D);
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= GNT_I;
      base_q       <= '0;
      issued_all_q <= 1'b0;
      mem_en       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      base_q       <= base_d;
      issued_all_q <= issued_all_d;
      mem_en       <= mem_en_d;
      mem_wr       <= mem_wr_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      i_done       <= i_done_d;
      d_done       <= d_done_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Scoreboard bench for cache_fill_arbiter: a transaction-level model predicts
// memory commands, fill beats and done pulses with their cycle numbers; a
// monitor pops and compares them whenever the DUT presents one.
module tb_cache_fill_arbiter;

  localparam int MEM_LAT = 4;
  localparam int WORDS   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_miss = 1'b0;
  logic [15:0] icache_addr = '0;
  logic        dcache_miss = 1'b0;
  logic        dcache_wr = 1'b0;
  logic [15:0] dcache_addr = '0;
  logic [15:0] dcache_wdata = '0;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_valid = 1'b0;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        ifill_we, dfill_we, i_done, d_done, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cache_fill_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icache_miss  (icache_miss),
    .icache_addr  (icache_addr),
    .dcache_miss  (dcache_miss),
    .dcache_wr    (dcache_wr),
    .dcache_addr  (dcache_addr),
    .dcache_wdata (dcache_wdata),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_valid    (mem_valid),
    .fill_data    (fill_data),
    .fill_word    (fill_word),
    .ifill_we     (ifill_we),
    .dfill_we     (dfill_we),
    .i_done       (i_done),
    .d_done       (d_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model: word at A holds A ^ 0xBEEF ----------------
  logic [15:0] pend [int];
  int inj_lo = -1;
  int inj_hi = -2;

  always @(negedge clk) begin
    if (mem_en && !mem_wr) pend[cyc + MEM_LAT] = mem_addr;
  end

  always @(posedge clk) begin
    #1;
    if (pend.exists(cyc)) begin
      mem_valid = 1'b1;
      mem_rdata = pend[cyc] ^ 16'hBEEF;
      pend.delete(cyc);
    end else if (cyc >= inj_lo && cyc <= inj_hi) begin
      mem_valid = 1'b1;
      mem_rdata = 16'($urandom);
    end else begin
      mem_valid = 1'b0;
      mem_rdata = 16'($urandom);
    end
  end

  // ---------------- scoreboard queues ----------------
  typedef struct { int cyc; bit wr; logic [15:0] addr; logic [15:0] data; } mem_ev_t;
  typedef struct { int cyc; bit dside; logic [2:0] word; logic [15:0] data; } fill_ev_t;
  typedef struct { int cyc; bit dside; } done_ev_t;

  mem_ev_t  exp_mem[$];
  fill_ev_t exp_fill[$];
  done_ev_t exp_done[$];

  // Block fill starting in IDLE at t0; events at or after 'abort' never happen.
  function automatic int sched_fill(bit dside, logic [15:0] addr, int t0, int abort);
    logic [15:0] base;
    logic [15:0] a;
    int issue_c, ret_c, done_c;
    base = addr & 16'hFFF0;
    for (int k = 0; k < WORDS; k++) begin
      a       = base + 16'(2 * k);
      issue_c = t0 + 1 + k;
      ret_c   = issue_c + MEM_LAT;
      if (issue_c < abort) exp_mem.push_back('{issue_c, 1'b0, a, 16'h0000});
      if (ret_c < abort)   exp_fill.push_back('{ret_c, dside, 3'(k), a ^ 16'hBEEF});
    end
    done_c = t0 + WORDS + MEM_LAT + 1;
    if (done_c < abort) exp_done.push_back('{done_c, dside});
    return done_c;
  endfunction

  function automatic int sched_write(logic [15:0] addr, logic [15:0] data, int t0);
    exp_mem.push_back('{t0 + 1, 1'b1, addr, data});
    exp_done.push_back('{t0 + 2, 1'b1});
    return t0 + 2;
  endfunction

  // Serve up to one I and one D request, arriving at ti/td, by priority.
  task automatic model_serve(bit has_i, logic [15:0] iaddr, int ti,
                             bit has_d, bit dwr, logic [15:0] daddr,
                             logic [15:0] wdata, int td);
    bit pi, pd;
    int t;
    pi = has_i;
    pd = has_d;
    t  = (has_i && (!has_d || ti <= td)) ? ti : td;
    while (pi || pd) begin
      if (pd && td <= t) begin
        if (dwr) t = sched_write(daddr, wdata, t);
        else     t = sched_fill(1'b1, daddr, t, 1 << 30);
        pd = 1'b0;
        t  = t + 1;
      end else if (pi && ti <= t) begin
        t  = sched_fill(1'b0, iaddr, t, 1 << 30);
        pi = 1'b0;
        t  = t + 1;
      end else begin
        t = t + 1;
      end
    end
  endtask

  // ---------------- monitor ----------------
  mem_ev_t  me;
  fill_ev_t fe;
  done_ev_t de;

  always @(negedge clk) begin
    if (mem_en) begin
      checks++;
      if (exp_mem.size() == 0) begin
        errors++;
        $display("FAIL mem_cmd unexpected: cyc=%0d wr=%0b addr=%h wdata=%h, required none",
                 cyc, mem_wr, mem_addr, mem_wdata);
      end else begin
        me = exp_mem.pop_front();
        if (cyc != me.cyc || mem_wr != me.wr || mem_addr != me.addr ||
            (me.wr && mem_wdata != me.data)) begin
          errors++;
          $display("FAIL mem_cmd: got cyc=%0d wr=%0b addr=%h wdata=%h, required cyc=%0d wr=%0b addr=%h wdata=%h",
                   cyc, mem_wr, mem_addr, mem_wdata, me.cyc, me.wr, me.addr, me.data);
        end
      end
    end
    if (ifill_we || dfill_we) begin
      checks++;
      if (exp_fill.size() == 0 || (ifill_we && dfill_we)) begin
        errors++;
        $display("FAIL fill unexpected: cyc=%0d iwe=%0b dwe=%0b word=%0d data=%h, required none",
                 cyc, ifill_we, dfill_we, fill_word, fill_data);
      end else begin
        fe = exp_fill.pop_front();
        if (cyc != fe.cyc || dfill_we != fe.dside || fill_word != fe.word || fill_data != fe.data) begin
          errors++;
          $display("FAIL fill: got cyc=%0d dside=%0b word=%0d data=%h, required cyc=%0d dside=%0b word=%0d data=%h",
                   cyc, dfill_we, fill_word, fill_data, fe.cyc, fe.dside, fe.word, fe.data);
        end
      end
    end
    if (i_done || d_done) begin
      checks++;
      if (exp_done.size() == 0 || (i_done && d_done)) begin
        errors++;
        $display("FAIL done unexpected: cyc=%0d i_done=%0b d_done=%0b, required none",
                 cyc, i_done, d_done);
      end else begin
        de = exp_done.pop_front();
        if (cyc != de.cyc || d_done != de.dside) begin
          errors++;
          $display("FAIL done: got cyc=%0d dside=%0b, required cyc=%0d dside=%0b",
                   cyc, d_done, de.cyc, de.dside);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_zero_outputs(string tag);
    logic [60:0] v;
    v = {mem_en, mem_wr, ifill_we, dfill_we, i_done, d_done, busy,
         mem_addr, mem_wdata, fill_word, 11'h0};
    checks++;
    if (v != '0) begin
      errors++;
      $display("FAIL %s outputs: got en=%0b wr=%0b iwe=%0b dwe=%0b id=%0b dd=%0b busy=%0b addr=%h wdata=%h word=%0d, required all 0",
               tag, mem_en, mem_wr, ifill_we, dfill_we, i_done, d_done, busy,
               mem_addr, mem_wdata, fill_word);
    end
  endtask

  // Raise requests at offsets from now, drop each on its done pulse.
  task automatic drive_group(bit has_i, logic [15:0] iaddr, int io,
                             bit has_d, bit dwr, logic [15:0] daddr,
                             logic [15:0] wdata, int doff);
    int t0, n;
    bit ifin, dfin;
    t0 = cyc;
    model_serve(has_i, iaddr, t0 + io, has_d, dwr, daddr, wdata, t0 + doff);
    ifin = !has_i;
    dfin = !has_d;
    n = 0;
    while (!(ifin && dfin) && n < 200) begin
      if (i_done && icache_miss) begin
        icache_miss = 1'b0;
        ifin = 1'b1;
      end
      if (d_done && (dcache_miss || dcache_wr)) begin
        dcache_miss = 1'b0;
        dcache_wr   = 1'b0;
        dfin = 1'b1;
      end
      if (has_i && !ifin && cyc == t0 + io) begin
        icache_addr = iaddr;
        icache_miss = 1'b1;
      end
      if (has_d && !dfin && cyc == t0 + doff) begin
        dcache_addr  = daddr;
        dcache_wdata = wdata;
        if (dwr) dcache_wr = 1'b1;
        else     dcache_miss = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(ifin && dfin)) begin
      errors++;
      $display("FAIL completion timeout: i_finished=%0b d_finished=%0b, required both 1", ifin, dfin);
      icache_miss = 1'b0;
      dcache_miss = 1'b0;
      dcache_wr   = 1'b0;
    end
  endtask

  // D fill aborted by reset in its 6th cycle, with memory beats still arriving.
  task automatic reset_mid_fill();
    int t0;
    t0 = cyc;
    void'(sched_fill(1'b1, 16'h4A18, t0, t0 + 6));
    dcache_addr = 16'h4A18;
    dcache_miss = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    dcache_miss = 1'b0;
    inj_lo = t0 + 7;
    inj_hi = t0 + 12;
    #1;
    check_zero_outputs("reset_mid_fill");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    while (cyc < t0 + 13) begin
      checks++;
      if (dfill_we || d_done || busy) begin
        errors++;
        $display("FAIL post_reset cyc=%0d: got dwe=%0b d_done=%0b busy=%0b, required 0 0 0",
                 cyc, dfill_we, d_done, busy);
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Stray memory beats while idle must not write anything or wake the FSM.
  task automatic spurious_valid();
    inj_lo = cyc + 1;
    inj_hi = cyc + 3;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ifill_we || dfill_we || busy || !mem_valid) begin
        errors++;
        $display("FAIL spurious_valid cyc=%0d: got iwe=%0b dwe=%0b busy=%0b valid=%0b, required 0 0 0 1",
                 cyc, ifill_we, dfill_we, busy, mem_valid);
      end
    end
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #3;
    check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    drive_group(1'b1, 16'h1236, 0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0);
    drive_group(1'b1, 16'h0040, 0, 1'b1, 1'b0, 16'h8008, 16'h0000, 0);
    drive_group(1'b0, 16'h0000, 0, 1'b1, 1'b1, 16'h2004, 16'hA5A5, 0);
    drive_group(1'b1, 16'h0106, 0, 1'b1, 1'b1, 16'h3003, 16'h5A5A, 3);
    reset_mid_fill();
    spurious_valid();

    for (int it = 0; it < 25; it++) begin
      bit hi, hd, wr;
      int sel;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sel = $urandom_range(1, 3);
      hi  = sel[0];
      hd  = sel[1];
      wr  = 1'($urandom_range(0, 1));
      drive_group(hi, 16'($urandom), $urandom_range(0, 15),
                  hd, wr, 16'($urandom), 16'($urandom), $urandom_range(0, 15));
    end

    repeat (10) @(negedge clk);
    checks++;
    if (exp_mem.size() != 0 || exp_fill.size() != 0 || exp_done.size() != 0) begin
      errors++;
      $display("FAIL leftover expectations: got mem=%0d fill=%0d done=%0d, required 0 0 0",
               exp_mem.size(), exp_fill.size(), exp_done.size());
    end
    checks++;
    if (busy || mem_en) begin
      errors++;
      $display("FAIL final idle: got busy=%0b mem_en=%0b, required 0 0", busy, mem_en);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
